fmul_sequencer: RTL and testbench
=================================

Name: fmul_sequencer

Overview:
- Control FSM for the single-precision float multiplier datapath.
- Replaces free-running clock division with explicit per-stage strobes on one clock:
  - operand capture
  - Booth mantissa multiply
  - product/exponent capture
  - iterative normalisation
  - result write
- Provides a start/done handshake to the requester and a timeout error if the multiplier never completes.

Parameters:
- MULT_CYCLES, 25, maximum cycles allowed for the Booth multiply (24-bit operands + 1).
- NORM_MAX, 46, maximum normalisation shift steps before forced exit.
- CNT_W, 8, width of the internal cycle/step counter; must hold max(MULT_CYCLES, NORM_MAX).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a multiply; sampled in IDLE only.
- mult_done  in  1  Booth unit finished; level, valid while high.
- norm_ok  in  1  normaliser reports mantissa[45]==1, mantissa==0 or exponent==0.
- ready  out  1  high in IDLE; the sequencer accepts start.
- busy  out  1  high in every state except IDLE.
- ld_operands  out  1  one-cycle strobe: capture a, b sign/exponent/mantissa.
- mult_start  out  1  one-cycle strobe: Booth unit begins.
- ld_product  out  1  one-cycle strobe: capture 48-bit product and biased exponent sum.
- norm_load  out  1  one-cycle strobe: normaliser loads product/exponent.
- norm_step  out  1  normaliser performs one shift-left / exponent-decrement.
- ld_result  out  1  one-cycle strobe: capture sign, exponent, mantissa into result register.
- done  out  1  one-cycle pulse: result register valid.
- err_timeout  out  1  sticky; set on multiply timeout, cleared by the next accepted start.

Behaviour:
- Reset state (reset low, asynchronous):
  - state=IDLE, counter=0
  - all strobes, busy, done and err_timeout = 0; ready=1
- States: IDLE, LOAD, MSTART, MWAIT, CAPT, NLOAD, NORM, WRITE, DONE.
- IDLE:
  - ready=1.
  - start=1 -> LOAD; clear err_timeout on the same edge.
- LOAD: ld_operands=1 -> MSTART.
- MSTART: mult_start=1; counter<=0 -> MWAIT.
- MWAIT:
  - mult_done=1 -> CAPT.
  - Otherwise counter++.
  - Counter reaches MULT_CYCLES-1 with mult_done=0 -> set err_timeout, go to WRITE. The result register is still written (garbage) so that done always follows start.
  - mult_done and the timeout in the same cycle -> mult_done wins; no error.
- CAPT: ld_product=1 -> NLOAD.
- NLOAD: norm_load=1; counter<=0 -> NORM.
- NORM:
  - norm_ok=1 -> WRITE, norm_step=0.
  - Otherwise norm_step=1 and counter++.
  - Counter reaches NORM_MAX -> WRITE regardless of norm_ok. Exactly NORM_MAX steps maximum; no error flag.
- WRITE: ld_result=1 -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Outputs are registered decodes of state, asserted during the state's cycle. No two load strobes are ever high together.
- Latency from the start edge to done high:
  - 6 + M + N cycles
  - M = MWAIT cycles (≥1), N = NORM cycles (≥1)
  - Minimum 8.
- start outside IDLE is ignored, not queued. start held high continuously -> back-to-back operations with one IDLE cycle between them.
- Reset asserted mid-operation:
  - immediate return to IDLE, all strobes low
  - no done pulse; datapath registers are not cleared by this block
- Counter arithmetic is unsigned CNT_W bits with no wrap. Both limits are checked before increment.

Decomposition:
- Shared package fmul_pkg holds:
  - state enum fmul_state_t (9 encodings)
  - constants EXP_BIAS=127, MANT_W=23, PROD_W=48, NORM_BIT=45
- One natural sub-module: fmul_step_counter. It provides a loadable up-counter with a limit-compare output (clear, enable, hit), used for both MWAIT and NORM.
- The FSM stays in fmul_sequencer.

Test Plan:
- Normal op: start=1 one cycle, mult_done high 3 cycles after mult_start, norm_ok high on the 2nd NORM cycle -> 1 ld_operands, 1 mult_start, 1 ld_product, 1 norm_load, exactly 1 norm_step, 1 ld_result, done at start+11, err_timeout=0.
- Already normalised: norm_ok=1 on entering NORM, mult_done after 1 cycle -> zero norm_step pulses, done at start+8 (minimum).
- Multiply timeout: mult_done tied 0 -> err_timeout set after 25 MWAIT cycles; no ld_product/norm_load; ld_result then done still occur; next start clears err_timeout.
- Normalise limit: norm_ok tied 0 -> exactly 46 norm_step cycles, then ld_result and done.
- Handshake: start pulses during busy are ignored (single done). start held high for 3 operations -> 3 done pulses, each followed by one ready cycle.
- Reset mid-NORM: drive reset low asynchronously between clock edges -> outputs drop immediately, state IDLE, ready=1, no done. After release, a fresh start completes normally.

Source files
------------

// File: rtl/fmul_pkg.sv
// Shared types and constants for the single-precision float multiplier control path.
package fmul_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_MSTART = 4'd2,
    S_MWAIT  = 4'd3,
    S_CAPT   = 4'd4,
    S_NLOAD  = 4'd5,
    S_NORM   = 4'd6,
    S_WRITE  = 4'd7,
    S_DONE   = 4'd8
  } fmul_state_t;

  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 23;
  localparam int PROD_W   = 48;
  localparam int NORM_BIT = 45;

endpackage

// File: rtl/fmul_sequencer_if.sv
// Requester/datapath handshake and stage strobes of the float multiplier sequencer.
interface fmul_sequencer_if;

  logic start;
  logic mult_done;
  logic norm_ok;
  logic ready;
  logic busy;
  logic ld_operands;
  logic mult_start;
  logic ld_product;
  logic norm_load;
  logic norm_step;
  logic ld_result;
  logic done;
  logic err_timeout;

  modport master (
    output start, mult_done, norm_ok,
    input  ready, busy, ld_operands, mult_start, ld_product,
           norm_load, norm_step, ld_result, done, err_timeout
  );

  modport slave (
    input  start, mult_done, norm_ok,
    output ready, busy, ld_operands, mult_start, ld_product,
           norm_load, norm_step, ld_result, done, err_timeout
  );

endinterface

// File: rtl/fmul_step_counter.sv
// Clearable up-counter with a limit compare; shared by the multiply wait and normalise loops.
module fmul_step_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_hit
);

  logic [CNT_W-1:0] r_count;

  // Saturates at all-ones so a missed limit can never wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_hit = (r_count == i_limit);

endmodule

// File: rtl/fmul_sequencer.sv
// Control FSM that strobes each stage of the float multiplier datapath on a single clock.
module fmul_sequencer
  import fmul_pkg::*;
#(
  parameter int MULT_CYCLES = 25,
  parameter int NORM_MAX    = 46,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  fmul_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] MULT_LIMIT = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] NORM_LIMIT = CNT_W'(NORM_MAX);

  fmul_state_t      r_state;
  fmul_state_t      w_state_next;
  logic             r_err_timeout;
  logic             w_cnt_clear;
  logic             w_cnt_enable;
  logic             w_cnt_hit;
  logic             w_timeout;
  logic [CNT_W-1:0] w_cnt_limit;

  fmul_step_counter #(.CNT_W(CNT_W)) u_step_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_cnt_clear),
    .i_enable (w_cnt_enable),
    .i_limit  (w_cnt_limit),
    .o_hit    (w_cnt_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Limits are compared before incrementing, so the counter value seen here is the step index.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clear  = 1'b0;
    w_cnt_enable = 1'b0;
    w_timeout    = 1'b0;
    w_cnt_limit  = NORM_LIMIT;
    case (r_state)
      S_IDLE:   if (bus.start) w_state_next = S_LOAD;
      S_LOAD:   w_state_next = S_MSTART;
      S_MSTART: begin
        w_cnt_clear  = 1'b1;
        w_state_next = S_MWAIT;
      end
      S_MWAIT: begin
        w_cnt_limit = MULT_LIMIT;
        if (bus.mult_done) begin
          w_state_next = S_CAPT;
        end else if (w_cnt_hit) begin
          w_timeout    = 1'b1;
          w_state_next = S_WRITE;
        end else begin
          w_cnt_enable = 1'b1;
        end
      end
      S_CAPT:   w_state_next = S_NLOAD;
      S_NLOAD: begin
        w_cnt_clear  = 1'b1;
        w_state_next = S_NORM;
      end
      S_NORM: begin
        if (bus.norm_ok || w_cnt_hit) begin
          w_state_next = S_WRITE;
        end else begin
          w_cnt_enable = 1'b1;
        end
      end
      S_WRITE:  w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // A timed-out request still produces a (garbage) result so done always follows start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_timeout <= 1'b0;
    end else if ((r_state == S_IDLE) && bus.start) begin
      r_err_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_err_timeout <= 1'b1;
    end
  end

  assign bus.ready       = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.ld_operands = (r_state == S_LOAD);
  assign bus.mult_start  = (r_state == S_MSTART);
  assign bus.ld_product  = (r_state == S_CAPT);
  assign bus.norm_load   = (r_state == S_NLOAD);
  assign bus.norm_step   = (r_state == S_NORM) && w_cnt_enable;
  assign bus.ld_result   = (r_state == S_WRITE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.err_timeout = r_err_timeout;

endmodule

// File: tb/tb_fmul_sequencer.sv
// Directed self-checking bench for fmul_sequencer with a reactive Booth/normaliser stand-in.
module tb_fmul_sequencer;

  logic clk;
  logic rst_n;

  fmul_sequencer_if bus ();

  fmul_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Datapath stand-in: mult_done on the cfg_m-th MWAIT cycle, norm_ok on the cfg_n-th NORM cycle (0 = never).
  int cfg_m = 0;
  int cfg_n = 0;
  int mw_cnt = 1000;
  int nm_cnt = 1000;

  int cnt_ld_operands, cnt_mult_start, cnt_ld_product, cnt_norm_load;
  int cnt_norm_step, cnt_ld_result, cnt_done, cnt_wait, cnt_overlap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    cnt_ld_operands = 0; cnt_mult_start = 0; cnt_ld_product = 0; cnt_norm_load = 0;
    cnt_norm_step = 0; cnt_ld_result = 0; cnt_done = 0; cnt_wait = 0; cnt_overlap = 0;
  endtask

  always @(negedge clk) begin
    if (bus.mult_start) mw_cnt = 0;
    else if (mw_cnt < 1000) mw_cnt++;
    if (bus.norm_load) nm_cnt = 0;
    else if (nm_cnt < 1000) nm_cnt++;
    bus.mult_done = (cfg_m != 0) && (mw_cnt == cfg_m);
    bus.norm_ok   = (cfg_n != 0) && (nm_cnt == cfg_n);

    if (bus.ld_operands) cnt_ld_operands++;
    if (bus.mult_start)  cnt_mult_start++;
    if (bus.ld_product)  cnt_ld_product++;
    if (bus.norm_load)   cnt_norm_load++;
    if (bus.norm_step)   cnt_norm_step++;
    if (bus.ld_result)   cnt_ld_result++;
    if (bus.done)        cnt_done++;
    if (bus.busy && !(bus.ld_operands | bus.mult_start | bus.ld_product | bus.norm_load |
                      bus.norm_step | bus.ld_result | bus.done))
      cnt_wait++;
    if ((32'(bus.ld_operands) + 32'(bus.ld_product) + 32'(bus.norm_load) + 32'(bus.ld_result)) > 1)
      cnt_overlap++;
  end

  // lat counts edges from the one that samples start (1) to the one that enters DONE.
  task automatic run_op(input string name, input int m, input int n, input bit poke,
                        output int lat, output logic err_at_start, output logic err_at_done);
    cfg_m = m;
    cfg_n = n;
    @(negedge clk);
    clear_counts();
    bus.start = 1'b1;
    lat = 0;
    err_at_start = 1'bx;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.start = 1'b0;
        err_at_start = bus.err_timeout;
      end
      if (poke && (lat == 4 || lat == 7)) bus.start = 1'b1;
      if (poke && (lat == 5 || lat == 8)) bus.start = 1'b0;
    end while (!bus.done && lat < 200);
    err_at_done = bus.err_timeout;
    if (lat >= 200) check({name, "_done_timeout"}, 0, 1);
    @(negedge clk);
    check({name, "_ready_after"}, bus.ready, 1);
    check({name, "_overlap"}, cnt_overlap, 0);
    $display("op %s: latency %0d, norm_step %0d, ld_product %0d, err_timeout %0b",
             name, lat, cnt_norm_step, cnt_ld_product, err_at_done);
  endtask

  int   lat;
  logic e_start, e_done;
  int   cyc, dones, last_done;

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.mult_done = 1'b0;
    bus.norm_ok = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err_timeout, 0);
    check("rst_strobes", {bus.ld_operands, bus.mult_start, bus.ld_product, bus.norm_load,
                          bus.norm_step, bus.ld_result, bus.done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal: M=3, N=2 -> 6+3+2
    run_op("normal", 3, 2, 1'b0, lat, e_start, e_done);
    check("normal_latency", lat, 11);
    check("normal_ld_operands", cnt_ld_operands, 1);
    check("normal_mult_start", cnt_mult_start, 1);
    check("normal_ld_product", cnt_ld_product, 1);
    check("normal_norm_load", cnt_norm_load, 1);
    check("normal_norm_step", cnt_norm_step, 1);
    check("normal_ld_result", cnt_ld_result, 1);
    check("normal_done", cnt_done, 1);
    check("normal_err", e_done, 0);

    // Minimum latency: M=1, N=1
    run_op("minimum", 1, 1, 1'b0, lat, e_start, e_done);
    check("min_latency", lat, 8);
    check("min_norm_step", cnt_norm_step, 0);

    // Multiply never completes: 25 MWAIT cycles, then WRITE, DONE
    run_op("timeout", 0, 1, 1'b0, lat, e_start, e_done);
    check("timeout_latency", lat, 29);
    check("timeout_wait_cycles", cnt_wait, 25);
    check("timeout_ld_product", cnt_ld_product, 0);
    check("timeout_norm_load", cnt_norm_load, 0);
    check("timeout_ld_result", cnt_ld_result, 1);
    check("timeout_err", e_done, 1);
    check("timeout_err_sticky", bus.err_timeout, 1);

    // Next accepted start clears the error
    run_op("after_timeout", 2, 1, 1'b0, lat, e_start, e_done);
    check("clear_err_at_start", e_start, 0);
    check("clear_err_at_done", e_done, 0);
    check("after_timeout_latency", lat, 9);

    // Normaliser never reports ok: 46 steps, 47 NORM cycles
    run_op("norm_limit", 1, 0, 1'b0, lat, e_start, e_done);
    check("normlim_steps", cnt_norm_step, 46);
    check("normlim_latency", lat, 54);
    check("normlim_ld_result", cnt_ld_result, 1);
    check("normlim_err", e_done, 0);

    // start pulses while busy are ignored
    run_op("poked", 3, 2, 1'b1, lat, e_start, e_done);
    repeat (12) @(negedge clk);
    check("poke_latency", lat, 11);
    check("poke_done_count", cnt_done, 1);
    check("poke_ld_operands", cnt_ld_operands, 1);

    // start held high: back-to-back with one IDLE cycle between
    cfg_m = 1;
    cfg_n = 1;
    @(negedge clk);
    clear_counts();
    bus.start = 1'b1;
    cyc = 0;
    dones = 0;
    last_done = 0;
    while (dones < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        dones++;
        if (dones == 1) check("held_first_done", cyc, 8);
        else check("held_spacing", cyc - last_done, 9);
        last_done = cyc;
        @(negedge clk);
        cyc++;
        check("held_ready", bus.ready, 1);
        if (dones == 3) bus.start = 1'b0;
      end
    end
    if (cyc >= 100) check("held_bound", 0, 1);
    repeat (12) @(negedge clk);
    check("held_done_count", cnt_done, 3);
    check("held_ld_operands", cnt_ld_operands, 3);
    $display("op held_start: %0d done pulses", cnt_done);

    // Asynchronous reset in the middle of NORM
    cfg_m = 1;
    cfg_n = 0;
    @(negedge clk);
    clear_counts();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.norm_step && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) check("midrst_reach_norm", 0, 1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", bus.ready, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_strobes", {bus.ld_operands, bus.mult_start, bus.ld_product, bus.norm_load,
                             bus.norm_step, bus.ld_result, bus.done}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_no_done", cnt_done, 0);
    check("midrst_no_ld_result", cnt_ld_result, 0);
    $display("op mid_norm_reset: done %0d, ready %0b", cnt_done, bus.ready);

    run_op("after_reset", 3, 2, 1'b0, lat, e_start, e_done);
    check("after_reset_latency", lat, 11);
    check("after_reset_norm_step", cnt_norm_step, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
